// File: rtl/bp_pkg.sv
// Types and widths shared between the gshare predictor and the branch resolve queue.
package bp_pkg;

   localparam int PC_W   = 7;
   localparam int HIST_W = 7;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [HIST_W-1:0] history;
      logic              pred_taken;
   } brq_entry_t;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } brq_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Bundle of the allocate/resolve/train traffic between the predictor pipeline and the resolve queue.
// Handshake: an allocation transfers on a rising edge where alloc_valid && alloc_ready; resolve_valid has no ready.
interface branch_resolve_queue_if #(
   parameter int PC_W   = bp_pkg::PC_W,
   parameter int HIST_W = bp_pkg::HIST_W,
   parameter int DEPTH  = 4
) ();
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              alloc_valid;
   logic              alloc_ready;
   logic [PC_W-1:0]   alloc_pc;
   logic [HIST_W-1:0] alloc_history;
   logic              alloc_pred_taken;
   logic              resolve_valid;
   logic              resolve_taken;
   logic              train_valid;
   logic [PC_W-1:0]   train_pc;
   logic [HIST_W-1:0] train_history;
   logic              train_taken;
   logic              train_mispredicted;
   logic              flush;
   logic              resolve_err;
   logic [CNT_W-1:0]  count;
   logic [15:0]       stat_resolved;
   logic [15:0]       stat_mispred;

   modport master (
      output alloc_valid, alloc_pc, alloc_history, alloc_pred_taken, resolve_valid, resolve_taken,
      input  alloc_ready, train_valid, train_pc, train_history, train_taken, train_mispredicted,
             flush, resolve_err, count, stat_resolved, stat_mispred
   );

   modport slave (
      input  alloc_valid, alloc_pc, alloc_history, alloc_pred_taken, resolve_valid, resolve_taken,
      output alloc_ready, train_valid, train_pc, train_history, train_taken, train_mispredicted,
             flush, resolve_err, count, stat_resolved, stat_mispred
   );
endinterface

// File: rtl/brq_entry_fifo.sv
// Circular storage of in-flight branch entries with occupancy tracking and a synchronous clear.
module brq_entry_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  brq_entry_t                 wdata_i,
   output brq_entry_t                 rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   brq_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Clear wins over any same-cycle push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; trains the predictor on resolve and flushes on mispredict.
// Optional BRQ_STATS_EN builds saturating resolved/mispredict counters; otherwise they read zero.
module branch_resolve_queue
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   branch_resolve_queue_if.slave        bus,
   output brq_state_t                   state_o
);
   brq_state_t  state_q, state_d;
   brq_entry_t  head, wentry;
   logic        full, empty, pop, push, mispred, err;

   logic              train_valid_q, train_taken_q, train_mis_q, flush_q, err_q;
   logic [PC_W-1:0]   train_pc_q;
   logic [HIST_W-1:0] train_hist_q;

   assign bus.alloc_ready = (state_q == RUN) && !full;
   assign push    = bus.alloc_valid && bus.alloc_ready;
   assign pop     = bus.resolve_valid && !empty && (state_q == RUN);
   assign err     = bus.resolve_valid && empty && (state_q == RUN);
   assign mispred = pop && (head.pred_taken ^ bus.resolve_taken);
   assign wentry  = '{pc: bus.alloc_pc, history: bus.alloc_history, pred_taken: bus.alloc_pred_taken};

   brq_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (mispred),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wentry),
      .rdata_o (head),
      .count_o (bus.count),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (mispred) state_d = RECOVER;
         RECOVER: state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RUN;
         train_valid_q <= 1'b0;
         train_pc_q    <= '0;
         train_hist_q  <= '0;
         train_taken_q <= 1'b0;
         train_mis_q   <= 1'b0;
         flush_q       <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         train_valid_q <= pop;
         flush_q       <= mispred;
         err_q         <= err;
         if (pop) begin
            train_pc_q    <= head.pc;
            train_hist_q  <= head.history;
            train_taken_q <= bus.resolve_taken;
            train_mis_q   <= mispred;
         end
      end
   end

`ifdef BRQ_STATS_EN
   logic [15:0] stat_res_q, stat_mis_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_res_q <= '0;
         stat_mis_q <= '0;
      end else begin
         if (pop)     stat_res_q <= sat_inc16(stat_res_q);
         if (mispred) stat_mis_q <= sat_inc16(stat_mis_q);
      end
   end

   assign bus.stat_resolved = stat_res_q;
   assign bus.stat_mispred  = stat_mis_q;
`else
   assign bus.stat_resolved = 16'h0000;
   assign bus.stat_mispred  = 16'h0000;
`endif

   assign bus.train_valid        = train_valid_q;
   assign bus.train_pc           = train_pc_q;
   assign bus.train_history      = train_hist_q;
   assign bus.train_taken        = train_taken_q;
   assign bus.train_mispredicted = train_mis_q;
   assign bus.flush              = flush_q;
   assign bus.resolve_err        = err_q;
   assign state_o                = state_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: queue-based reference model plus directed literal checks.
module tb_branch_resolve_queue;
   import bp_pkg::*;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [6:0] pc;
      logic [6:0] hist;
      logic       pred;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   brq_state_t dbg_state;

   branch_resolve_queue_if #(.PC_W(7), .HIST_W(7), .DEPTH(DEPTH)) bus ();

   branch_resolve_queue #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .state_o (dbg_state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   ent_t        exp_q[$];
   bit          m_rec;
   bit          e_tv, e_taken, e_mis, e_flush, e_err;
   logic [6:0]  e_pc, e_hist;
   logic [15:0] e_sr, e_sm;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         m_rec = 0; e_tv = 0; e_taken = 0; e_mis = 0; e_flush = 0; e_err = 0;
         e_pc = 0; e_hist = 0; e_sr = 0; e_sm = 0;
      end else begin
         bit   ready, do_pop, do_err, mis;
         ent_t h;
         ready  = !m_rec && (exp_q.size() < DEPTH);
         do_pop = bus.resolve_valid && !m_rec && (exp_q.size() > 0);
         do_err = bus.resolve_valid && !m_rec && (exp_q.size() == 0);
         mis    = 0;
         e_tv   = do_pop;
         if (do_pop) begin
            h       = exp_q.pop_front();
            mis     = h.pred != bus.resolve_taken;
            e_pc    = h.pc;
            e_hist  = h.hist;
            e_taken = bus.resolve_taken;
            e_mis   = mis;
            if (e_sr != 16'hFFFF) e_sr = e_sr + 1;
            if (mis && e_sm != 16'hFFFF) e_sm = e_sm + 1;
         end
         if (mis) exp_q.delete();
         else if (bus.alloc_valid && ready)
            exp_q.push_back('{pc: bus.alloc_pc, hist: bus.alloc_history, pred: bus.alloc_pred_taken});
         m_rec   = mis;
         e_flush = mis;
         e_err   = do_err;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         chk("alloc_ready", {31'd0, bus.alloc_ready}, {31'd0, !m_rec && exp_q.size() < DEPTH});
         chk("count", {29'd0, bus.count}, exp_q.size());
         chk("train_valid", {31'd0, bus.train_valid}, {31'd0, e_tv});
         chk("flush", {31'd0, bus.flush}, {31'd0, e_flush});
         chk("resolve_err", {31'd0, bus.resolve_err}, {31'd0, e_err});
         if (e_tv) begin
            chk("train_pc", {25'd0, bus.train_pc}, {25'd0, e_pc});
            chk("train_history", {25'd0, bus.train_history}, {25'd0, e_hist});
            chk("train_taken", {31'd0, bus.train_taken}, {31'd0, e_taken});
            chk("train_mispredicted", {31'd0, bus.train_mispredicted}, {31'd0, e_mis});
         end
`ifdef BRQ_STATS_EN
         chk("stat_resolved", {16'd0, bus.stat_resolved}, {16'd0, e_sr});
         chk("stat_mispred", {16'd0, bus.stat_mispred}, {16'd0, e_sm});
`else
         chk("stat_resolved", {16'd0, bus.stat_resolved}, 32'd0);
         chk("stat_mispred", {16'd0, bus.stat_mispred}, 32'd0);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input bit av, input logic [6:0] pc, input logic [6:0] hist, input bit pred,
                        input bit rv, input bit rt);
      @(negedge clk);
      bus.alloc_valid      = av;
      bus.alloc_pc         = pc;
      bus.alloc_history    = hist;
      bus.alloc_pred_taken = pred;
      bus.resolve_valid    = rv;
      bus.resolve_taken    = rt;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 7'd0, 7'd0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n                = 1'b0;
      bus.alloc_valid      = 1'b0;
      bus.alloc_pc         = '0;
      bus.alloc_history    = '0;
      bus.alloc_pred_taken = 1'b0;
      bus.resolve_valid    = 1'b0;
      bus.resolve_taken    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      do_reset();
      chk("reset alloc_ready", {31'd0, bus.alloc_ready}, 32'd1);
      chk("reset count", {29'd0, bus.count}, 32'd0);
      chk("reset train_valid", {31'd0, bus.train_valid}, 32'd0);

      // Single mispredicted branch
      drive(1, 7'd10, 7'd0, 0, 0, 0);
      drive(0, 7'd0, 7'd0, 0, 1, 1);
      after_edge();
      chk("t1 train_valid", {31'd0, bus.train_valid}, 32'd1);
      chk("t1 train_pc", {25'd0, bus.train_pc}, 32'd10);
      chk("t1 train_history", {25'd0, bus.train_history}, 32'd0);
      chk("t1 train_taken", {31'd0, bus.train_taken}, 32'd1);
      chk("t1 mispredicted", {31'd0, bus.train_mispredicted}, 32'd1);
      chk("t1 flush", {31'd0, bus.flush}, 32'd1);
      chk("t1 alloc_ready", {31'd0, bus.alloc_ready}, 32'd0);
      chk("t1 count", {29'd0, bus.count}, 32'd0);
      idle(2);

      // Two correctly predicted branches train in order
      drive(1, 7'd10, 7'd1, 0, 0, 0);
      drive(1, 7'd20, 7'd2, 0, 0, 0);
      drive(0, 7'd0, 7'd0, 0, 1, 0);
      after_edge();
      chk("t2 first pc", {25'd0, bus.train_pc}, 32'd10);
      chk("t2 first mis", {31'd0, bus.train_mispredicted}, 32'd0);
      drive(0, 7'd0, 7'd0, 0, 1, 0);
      after_edge();
      chk("t2 second pc", {25'd0, bus.train_pc}, 32'd20);
      chk("t2 flush", {31'd0, bus.flush}, 32'd0);
      chk("t2 count", {29'd0, bus.count}, 32'd0);
      idle(1);

      // Fill, then alloc+resolve when full: alloc dropped
      for (int i = 1; i <= 4; i++) drive(1, 7'(i), 7'(i), 0, 0, 0);
      after_edge();
      chk("t3 full count", {29'd0, bus.count}, 32'd4);
      chk("t3 full ready", {31'd0, bus.alloc_ready}, 32'd0);
      drive(1, 7'd50, 7'd0, 0, 1, 0);
      #1 chk("t3 ready during resolve", {31'd0, bus.alloc_ready}, 32'd0);
      after_edge();
      chk("t3 count after", {29'd0, bus.count}, 32'd3);
      chk("t3 train pc", {25'd0, bus.train_pc}, 32'd1);
      // Reset with a train pulse pending and three entries held
      rst_n = 1'b0;
      #1;
      chk("rst count", {29'd0, bus.count}, 32'd0);
      chk("rst train_valid", {31'd0, bus.train_valid}, 32'd0);
      chk("rst flush", {31'd0, bus.flush}, 32'd0);
      do_reset();

      // Mispredict squashes younger entries
      drive(1, 7'd14, 7'd3, 1, 0, 0);
      drive(1, 7'd20, 7'd4, 1, 0, 0);
      drive(1, 7'd30, 7'd5, 1, 0, 0);
      drive(0, 7'd0, 7'd0, 0, 1, 0);
      after_edge();
      chk("t4 train pc", {25'd0, bus.train_pc}, 32'd14);
      chk("t4 mis", {31'd0, bus.train_mispredicted}, 32'd1);
      chk("t4 flush", {31'd0, bus.flush}, 32'd1);
      chk("t4 count", {29'd0, bus.count}, 32'd0);
      idle(4);

      // Resolve while empty
      drive(0, 7'd0, 7'd0, 0, 1, 1);
      after_edge();
      chk("t5 resolve_err", {31'd0, bus.resolve_err}, 32'd1);
      chk("t5 train_valid", {31'd0, bus.train_valid}, 32'd0);
      idle(1);

      // Statistics: 3 correct, 2 mispredicted
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 7'(40 + i), 7'd0, 0, 0, 0);
         drive(0, 7'd0, 7'd0, 0, 1, 0);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1, 7'(60 + i), 7'd0, 0, 0, 0);
         drive(0, 7'd0, 7'd0, 0, 1, 1);
         idle(1);
      end
      after_edge();
`ifdef BRQ_STATS_EN
      chk("stats resolved", {16'd0, bus.stat_resolved}, 32'd5);
      chk("stats mispred", {16'd0, bus.stat_mispred}, 32'd2);
`else
      chk("stats resolved", {16'd0, bus.stat_resolved}, 32'd0);
      chk("stats mispred", {16'd0, bus.stat_mispred}, 32'd0);
`endif

      // Random traffic against the model
      for (int i = 0; i < 500; i++) begin
         drive($urandom_range(0, 99) < 60, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
               1'($urandom_range(0, 1)), $urandom_range(0, 99) < 45, 1'($urandom_range(0, 1)));
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
Downstream neighbour of the gshare predictor. Captures each prediction (pc, history snapshot, predicted direction) into an in-order queue of in-flight branches. When execute resolves the oldest branch, the block compares the actual outcome with the prediction and drives the predictor's train port.
On a misprediction it flushes all younger (wrong-path) entries and holds allocation for one recovery cycle.

Parameters:
PC_W, 7, branch pc width (matches predictor pc width)
HIST_W, 7, global history width (matches predictor history width)
DEPTH, 4, queue entries; power of 2, >=2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_valid  in  1  new prediction to record
alloc_ready  out  1  queue can accept; combinational = (state==RUN) && !full
alloc_pc  in  PC_W  predicted branch pc
alloc_history  in  HIST_W  history used for the prediction (predictor's predict_history)
alloc_pred_taken  in  1  predicted direction (predictor's predict_taken)
resolve_valid  in  1  oldest in-flight branch resolved this cycle
resolve_taken  in  1  actual direction
train_valid  out  1  registered train strobe to predictor
train_pc  out  PC_W  pc of resolved branch
train_history  out  HIST_W  saved history of resolved branch
train_taken  out  1  actual direction
train_mispredicted  out  1  pred != actual
flush  out  1  registered pulse; squash younger pipeline work
resolve_err  out  1  registered pulse; resolve_valid seen while queue empty
count  out  $clog2(DEPTH+1)  current occupancy
stat_resolved  out  16  resolved-branch counter (optional feature)
stat_mispred  out  16  mispredict counter (optional feature)

Behaviour:
- Reset (async, rst_n low): pointers=0, count=0, state=RUN, all registered outputs 0. After reset, alloc_ready=1.
- Storage: circular FIFO. wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- Allocate: alloc_valid && alloc_ready at a rising edge writes {pc, history, pred_taken} at wr_ptr and increments wr_ptr.
- Resolve: resolve_valid && !empty at an edge pops the head entry.
  - The next cycle, train_valid=1 for exactly one cycle.
  - train_pc and train_history are the head entry's fields; train_taken = resolve_taken; train_mispredicted = head.pred_taken ^ resolve_taken.
  - Total latency: 1 cycle.
- Resolve on empty: no pop and no train. resolve_err pulses high for 1 cycle.
- Simultaneous alloc and resolve without mispredict: both happen and count is unchanged.
  - When full, alloc_ready stays 0 even if a resolve occurs the same cycle. No bypass.
- Mispredict (resolve pops an entry with pred != actual):
  - At that edge, all entries are discarded: wr_ptr=rd_ptr=0, count=0.
  - A same-cycle allocation is also dropped.
  - Next cycle: flush=1, train_valid=1, train_mispredicted=1, state=RECOVER.
- FSM:
  - RUN: normal operation. A mispredicting resolve moves to RECOVER.
  - RECOVER: lasts exactly 1 cycle. alloc_ready=0; resolve_valid is ignored (no pop, no err). Always returns to RUN.
- count is updated at the same edge as the push/pop and is never negative or above DEPTH.
- Reset asserted mid-operation: the queue empties immediately; any pending train/flush pulse is cancelled.

Optional Feature:
- Macro: BRQ_STATS_EN.
- Defined: stat_resolved increments on every successful pop; stat_mispred increments on every mispredicting pop. Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: counters are not built; both ports are tied to 16'h0000. The interface is unchanged.

Decomposition:
- Shared package bp_pkg holds:
  - PC_W and HIST_W defaults, shared with the predictor.
  - The brq_entry_t typedef {pc, history, pred_taken}.
  - The state enum {RUN, RECOVER}.
- One natural sub-module: brq_entry_fifo. It holds the storage array, the pointers, count, full and empty, and a synchronous clear input used for flush.
- Control FSM, train register and stats counters stay in the top level.

Test Plan:
- Reset, then alloc pc=10/hist=0/pred=0; resolve taken=1 -> one cycle later train_valid=1, pc=10, hist=0, taken=1, mispredicted=1, flush=1; next cycle alloc_ready=0; count=0.
- Alloc pc=10 pred=0, then pc=20 pred=0; resolve taken=0 twice -> two train pulses in order pc=10 then pc=20, mispredicted=0, flush never high, count returns 0.
- Fill 4 entries -> alloc_ready=0, count=4; 5th alloc is dropped; with simultaneous resolve (correct), alloc_ready stays 0 and count becomes 3.
- Alloc pc=14, 20, 30 (pred=1 each); resolve pc=14 with taken=0 -> train pc=14 mispredicted=1, flush=1, count=0. pc=20 and pc=30 never appear on train.
- Resolve_valid while empty -> resolve_err pulse, no train_valid. Assert rst_n low while count=3 -> count=0 and all outputs 0 immediately.
- With BRQ_STATS_EN: 3 correct and 2 mispredicted resolves -> stat_resolved=5, stat_mispred=2. Without the macro both read 0.
